pn_seq_ctrl: RTL and testbench
==============================

// Module: pn_seq_ctrl
// PURPOSE
//  Sequencer for the sounder PN generator (LFSR with ena/strobe/mask inputs).
//  Selects the feedback mask for a maximal-length sequence of the chosen degree.
//  Paces chip strobes with a programmable divider.
//  Counts chips and whole sequences, and runs either N sequences or continuously.
//  Sits between the sounder control registers and the LFSR instance in the TX/RX chain.
// PARAMETERS
//  WIDTH    16  LFSR register width; must equal the LFSR instance width, valid 16 only
//  DIV_W    16  width of chip-rate divider
//  BURST_W  16  width of sequence-count request/counter
// PORTS
//  clk_i           in   1        system clock
//  rst_n_i         in   1        reset, asynchronous, active-low
//  start_i         in   1        one-cycle pulse: latch config, begin run
//  stop_i          in   1        one-cycle pulse: abort run
//  degree_i        in   5        PN degree n, valid 2..16; sequence length L=2^n-1
//  div_i           in   DIV_W    chip period = div_i+1 clocks
//  nseq_i          in   BURST_W  sequences to run; 0 = continuous until stop_i
//  lfsr_ena_o      out  1        to LFSR ena_i; low forces LFSR to state 1
//  lfsr_strobe_o   out  1        to LFSR strobe_i; one-cycle chip advance
//  lfsr_mask_o     out  WIDTH    to LFSR mask_i
//  sof_o           out  1        pulse: current pn_o is chip 0 of a sequence
//  chip_cnt_o      out  16       index of chip currently on pn_o, 0..L-1
//  busy_o          out  1        high in ARM/RUN/DONE
//  done_o          out  1        one-cycle pulse on normal completion
//  cfg_err_o       out  1        one-cycle pulse: start_i with invalid degree_i
// BEHAVIOUR
//  - All outputs registered; reset value 0 for every output (lfsr_mask_o = 0).
//  - States: IDLE, ARM, RUN, DONE. Reset -> IDLE.
//  - IDLE: ena=0, strobe=0.
//      start_i & ~stop_i & degree in 2..16 -> latch degree/div/nseq, go to ARM.
//      start_i & ~stop_i & invalid degree -> cfg_err_o=1 next cycle, stay in IDLE.
//      start_i & stop_i -> stop wins; stay in IDLE, no error.
//  - ARM (1 cycle): ena=0 (guarantees LFSR=1), mask driven from table,
//    divider=0, chip=0, seq=0 -> RUN.
//  - RUN: ena=1.
//      Divider counts 0..div, wraps to 0; strobe=1 in the cycle after div is reached.
//      div=0 -> strobe every cycle.
//      First strobe occurs div+1 cycles after RUN entry.
//  - Timing: start_i at cycle t -> ARM t+1 -> RUN t+2.
//      In cycle t+2: lfsr_ena_o=1, sof_o=1, chip_cnt_o=0.
//  - chip_cnt_o increments on each strobe. The strobe at chip L-1 wraps chip to 0,
//    pulses sof_o, and increments seq.
//  - Completion: on that wrap, if nseq!=0 and seq+1==nseq -> DONE (no sof_o), else stay in RUN.
//  - nseq=0: seq counter wraps freely; RUN never ends except on stop_i.
//  - DONE (1 cycle): ena=0, done_o=1 -> IDLE.
//  - stop_i in ARM/RUN -> IDLE next cycle; ena=0; no done_o; in-flight strobe suppressed.
//  - start_i while busy ignored. Config inputs ignored outside the start cycle.
//  - Async reset mid-run: immediate return to IDLE, all outputs 0.
//  - Mask table (bit i-1 = tap i), n:mask hex:
//      2:0003  3:0006  4:000C  5:0014  6:0030  7:0060  8:00B8  9:0110
//      10:0240 11:0500 12:0E08 13:1C80 14:3802 15:6000 16:D008
//  - Mask is held while busy and stays at its last value in IDLE.
// TESTING
//  1 n=4, div=0, nseq=2, start -> sof_o at RUN cycles 0 and 15; 30 strobes total;
//    done_o 1 cycle after 30th strobe; pn_o (with LFSR) has period 15, starts at 1.
//  2 n=16, div=0, nseq=1 -> 65535 strobes, LFSR returns to 0x0001 exactly at the end;
//    no earlier repeat of 0x0001.
//  3 n=5, div=3, nseq=0 -> strobe every 4th cycle, first at RUN cycle 4; runs >3 periods;
//    stop_i -> ena=0 next cycle, no done_o.
//  4 start with degree 1, then 17 -> cfg_err_o pulse each time, busy_o stays 0;
//    start+stop same cycle -> nothing.
//  5 Drop rst_n_i mid-RUN (n=8) -> all outputs 0 immediately;
//    fresh start -> sof_o at RUN cycle 0, chip_cnt_o=0.
//  6 start_i and new degree_i pulsed during RUN -> ignored; mask and period unchanged.

Source files
------------

// File: rtl/pn_seq_ctrl.sv
// -----------------------------------------------------------------------------
// pn_seq_ctrl
//   Sequencer for the sounder PN generator. Picks the feedback mask for a
//   maximal-length LFSR sequence of the requested degree, paces chip strobes
//   with a programmable divider, and counts chips and whole sequences. It runs
//   either a fixed number of sequences or continuously until stopped.
//
// Parameters
//   WIDTH    LFSR register width (must match the LFSR instance; 16 only)
//   DIV_W    width of the chip-rate divider
//   BURST_W  width of the sequence-count request / counter
//
// Ports
//   clk_i          system clock
//   rst_n_i        asynchronous active-low reset
//   start_i        pulse: latch config and begin a run
//   stop_i         pulse: abort the run (wins over start_i)
//   degree_i       PN degree n (2..16), sequence length L = 2^n-1
//   div_i          chip period = div_i+1 clocks
//   nseq_i         sequences to run, 0 = continuous
//   lfsr_ena_o     LFSR enable (low forces LFSR state to 1)
//   lfsr_strobe_o  one-cycle chip advance
//   lfsr_mask_o    LFSR feedback mask
//   sof_o          pulse: current chip is chip 0 of a sequence
//   chip_cnt_o     index of the current chip, 0..L-1
//   busy_o         high in ARM/RUN/DONE
//   done_o         pulse on normal completion
//   cfg_err_o      pulse: start_i with an invalid degree
// -----------------------------------------------------------------------------
module pn_seq_ctrl #(
  parameter int WIDTH   = 16,
  parameter int DIV_W   = 16,
  parameter int BURST_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic [4:0]         degree_i,
  input  logic [DIV_W-1:0]   div_i,
  input  logic [BURST_W-1:0] nseq_i,
  output logic               lfsr_ena_o,
  output logic               lfsr_strobe_o,
  output logic [WIDTH-1:0]   lfsr_mask_o,
  output logic               sof_o,
  output logic [15:0]        chip_cnt_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               cfg_err_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Feedback masks for maximal-length sequences, bit i-1 = tap i.
  function automatic logic [WIDTH-1:0] mask_lut(input logic [4:0] n);
    logic [15:0] m;
    case (n)
      5'd2:    m = 16'h0003;
      5'd3:    m = 16'h0006;
      5'd4:    m = 16'h000C;
      5'd5:    m = 16'h0014;
      5'd6:    m = 16'h0030;
      5'd7:    m = 16'h0060;
      5'd8:    m = 16'h00B8;
      5'd9:    m = 16'h0110;
      5'd10:   m = 16'h0240;
      5'd11:   m = 16'h0500;
      5'd12:   m = 16'h0E08;
      5'd13:   m = 16'h1C80;
      5'd14:   m = 16'h3802;
      5'd15:   m = 16'h6000;
      5'd16:   m = 16'hD008;
      default: m = 16'h0000;
    endcase
    return WIDTH'(m);
  endfunction

  state_t             state_q;
  logic [4:0]         deg_q;
  logic [DIV_W-1:0]   div_q;
  logic [BURST_W-1:0] nseq_q;
  logic [DIV_W-1:0]   div_cnt_q;
  logic [BURST_W-1:0] seq_q;
  logic               fin_q;      // final strobe of the run has been issued
  logic               ena_q;
  logic               strobe_q;
  logic [WIDTH-1:0]   mask_q;
  logic               sof_q;
  logic [15:0]        chip_q;
  logic               busy_q;
  logic               done_q;
  logic               cfg_err_q;

  logic               deg_ok_d;
  logic [WIDTH-1:0]   mask_d;
  logic [15:0]        last_chip_d;
  logic               div_hit_d;
  logic               chip_wrap_d;
  logic [BURST_W-1:0] seq_inc_d;
  logic               last_seq_d;

  always_comb begin
    deg_ok_d    = (degree_i >= 5'd2) && (degree_i <= 5'd16);
    mask_d      = mask_lut(degree_i);
    // L-1 = 2^n - 2, computed one bit wider so n=16 does not overflow.
    last_chip_d = 16'((17'd1 << deg_q) - 17'd2);
    div_hit_d   = (div_cnt_q == div_q);
    chip_wrap_d = (chip_q == last_chip_d);
    seq_inc_d   = seq_q + BURST_W'(1);
    last_seq_d  = (nseq_q != '0) && (seq_inc_d == nseq_q);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      deg_q     <= '0;
      div_q     <= '0;
      nseq_q    <= '0;
      div_cnt_q <= '0;
      seq_q     <= '0;
      fin_q     <= 1'b0;
      ena_q     <= 1'b0;
      strobe_q  <= 1'b0;
      mask_q    <= '0;
      sof_q     <= 1'b0;
      chip_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      // Pulse outputs default low every cycle.
      strobe_q  <= 1'b0;
      sof_q     <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          ena_q <= 1'b0;
          if (start_i && !stop_i) begin
            if (deg_ok_d) begin
              deg_q   <= degree_i;
              div_q   <= div_i;
              nseq_q  <= nseq_i;
              mask_q  <= mask_d;
              busy_q  <= 1'b1;
              state_q <= ST_ARM;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end

        // One cycle with ena low so the LFSR sits at state 1 before RUN.
        ST_ARM: begin
          if (stop_i) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            div_cnt_q <= '0;
            chip_q    <= '0;
            seq_q     <= '0;
            fin_q     <= 1'b0;
            ena_q     <= 1'b1;
            sof_q     <= 1'b1;
            state_q   <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (stop_i) begin
            ena_q   <= 1'b0;
            busy_q  <= 1'b0;
            chip_q  <= '0;
            fin_q   <= 1'b0;
            state_q <= ST_IDLE;
          end else if (fin_q) begin
            // Last strobe was on the wire last cycle; finish now.
            ena_q   <= 1'b0;
            done_q  <= 1'b1;
            fin_q   <= 1'b0;
            state_q <= ST_DONE;
          end else begin
            div_cnt_q <= div_hit_d ? '0 : div_cnt_q + DIV_W'(1);
            if (div_hit_d) begin
              strobe_q <= 1'b1;
              if (chip_wrap_d) begin
                chip_q <= '0;
                if (last_seq_d) begin
                  fin_q <= 1'b1;
                end else begin
                  sof_q <= 1'b1;
                  seq_q <= seq_inc_d;
                end
              end else begin
                chip_q <= chip_q + 16'd1;
              end
            end
          end
        end

        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: begin
          ena_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign lfsr_ena_o    = ena_q;
  assign lfsr_strobe_o = strobe_q;
  assign lfsr_mask_o   = mask_q;
  assign sof_o         = sof_q;
  assign chip_cnt_o    = chip_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign cfg_err_o     = cfg_err_q;

endmodule

// File: tb/tb_pn_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pn_seq_ctrl
//   Directed bench for pn_seq_ctrl. A small Fibonacci LFSR model is driven by
//   the DUT's ena/strobe/mask outputs so sequence periods can be observed.
// -----------------------------------------------------------------------------
module tb_pn_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic [4:0]  degree;
  logic [15:0] div_v;
  logic [15:0] nseq;
  logic        ena;
  logic        stb;
  logic [15:0] mask;
  logic        sof;
  logic [15:0] chip;
  logic        busy;
  logic        done;
  logic        cerr;

  int tests = 0;
  int fails = 0;

  // Results of the last run() call
  int r_strobes;
  int r_done;
  int r_sofs;
  int r_first_stb;
  int r_first_rep;
  int r_reps;
  int r_chip_cap;
  int sof_at [4];
  logic [15:0] cur_lmask;

  logic [15:0] lfsr_m;

  always #5 clk = ~clk;

  pn_seq_ctrl #(.WIDTH(16), .DIV_W(16), .BURST_W(16)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .stop_i(stop),
    .degree_i(degree), .div_i(div_v), .nseq_i(nseq),
    .lfsr_ena_o(ena), .lfsr_strobe_o(stb), .lfsr_mask_o(mask),
    .sof_o(sof), .chip_cnt_o(chip), .busy_o(busy), .done_o(done),
    .cfg_err_o(cerr)
  );

  // LFSR stand-in: shift left, new bit0 = parity of tapped bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      lfsr_m <= 16'd1;
    else if (!ena)   lfsr_m <= 16'd1;
    else if (stb)    lfsr_m <= {lfsr_m[14:0], ^(lfsr_m & mask)};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start with the given config; returns in the ARM cycle.
  task automatic start_run(input int d, input int dv, input int ns);
    degree    = 5'(d);
    div_v     = 16'(dv);
    nseq      = 16'(ns);
    cur_lmask = 16'((17'd1 << d) - 17'd1);
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  // Called in RUN cycle 0; steps up to budget cycles, stopping at done_o.
  task automatic run(input int budget, input int poke_cyc, input int cap_cyc);
    bit prev_stb;
    prev_stb    = 1'b0;
    r_strobes   = 0;
    r_done      = -1;
    r_sofs      = 0;
    r_first_stb = -1;
    r_first_rep = -1;
    r_reps      = 0;
    r_chip_cap  = -1;
    for (int k = 0; k < 4; k++) sof_at[k] = -1;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      tick();
      if (cyc == poke_cyc + 1) start = 1'b0;
      if (prev_stb && ((lfsr_m & cur_lmask) == 16'd1)) begin
        if (r_first_rep < 0) r_first_rep = r_strobes;
        r_reps++;
      end
      prev_stb = stb;
      if (stb) begin
        r_strobes++;
        if (r_first_stb < 0) r_first_stb = cyc;
      end
      if (sof) begin
        if (r_sofs < 4) sof_at[r_sofs] = cyc;
        r_sofs++;
      end
      if (cyc == cap_cyc) r_chip_cap = int'(chip);
      if (cyc == poke_cyc) begin
        start = 1'b1; degree = 5'd9; div_v = 16'd0; nseq = 16'd5;
      end
      if (done) begin
        r_done = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    tests++; if ({ena, stb, sof, busy, done, cerr} !== 6'b0) begin fails++;
      $display("FAIL reset_ctl: got %b expected 000000", {ena, stb, sof, busy, done, cerr}); end
    tests++; if (mask !== 16'h0000) begin fails++;
      $display("FAIL reset_mask: got %h expected 0000", mask); end
    tests++; if (chip !== 16'h0000) begin fails++;
      $display("FAIL reset_chip: got %h expected 0000", chip); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tests++; if ({ena, stb, sof, busy, done, cerr} !== 6'b0) begin fails++;
      $display("FAIL idle_ctl: got %b expected 000000", {ena, stb, sof, busy, done, cerr}); end
    $display("[TB] test_reset done");
  endtask

  task automatic test_masks();
    logic [15:0] exp_mask [15];
    exp_mask = '{16'h0003, 16'h0006, 16'h000C, 16'h0014, 16'h0030, 16'h0060,
                 16'h00B8, 16'h0110, 16'h0240, 16'h0500, 16'h0E08, 16'h1C80,
                 16'h3802, 16'h6000, 16'hD008};
    for (int d = 2; d <= 16; d++) begin
      start_run(d, 0, 0);
      tests++; if (mask !== exp_mask[d-2]) begin fails++;
        $display("FAIL mask_n%0d: got %h expected %h", d, mask, exp_mask[d-2]); end
      tests++; if (busy !== 1'b1 || ena !== 1'b0) begin fails++;
        $display("FAIL arm_n%0d busy/ena: got %b%b expected 10", d, busy, ena); end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      tests++; if (busy !== 1'b0) begin fails++;
        $display("FAIL arm_stop_n%0d busy: got %b expected 0", d, busy); end
    end
    tests++; if (mask !== 16'hD008) begin fails++;
      $display("FAIL mask_held_idle: got %h expected d008", mask); end
    $display("[TB] test_masks done");
  endtask

  task automatic test_cfg_err();
    int bad [2];
    bad = '{1, 17};
    for (int i = 0; i < 2; i++) begin
      degree = 5'(bad[i]);
      start  = 1'b1;
      tick();
      start  = 1'b0;
      tests++; if (cerr !== 1'b1 || busy !== 1'b0) begin fails++;
        $display("FAIL cfg_err_n%0d: got err=%b busy=%b expected err=1 busy=0", bad[i], cerr, busy); end
      tick();
      tests++; if (cerr !== 1'b0 || busy !== 1'b0) begin fails++;
        $display("FAIL cfg_err_pulse_n%0d: got err=%b busy=%b expected 0 0", bad[i], cerr, busy); end
    end
    // start and stop together: nothing happens, valid or invalid degree
    for (int i = 0; i < 2; i++) begin
      degree = (i == 0) ? 5'd4 : 5'd1;
      start  = 1'b1;
      stop   = 1'b1;
      tick();
      start  = 1'b0;
      stop   = 1'b0;
      tests++; if (busy !== 1'b0 || cerr !== 1'b0) begin fails++;
        $display("FAIL start_stop_%0d: got busy=%b err=%b expected 0 0", i, busy, cerr); end
      tick();
      tests++; if (busy !== 1'b0 || ena !== 1'b0) begin fails++;
        $display("FAIL start_stop_late_%0d: got busy=%b ena=%b expected 0 0", i, busy, ena); end
    end
    tests++; if (mask !== 16'hD008) begin fails++;
      $display("FAIL mask_after_err: got %h expected d008", mask); end
    $display("[TB] test_cfg_err done");
  endtask

  task automatic test_seq_n4();
    start_run(4, 0, 2);
    tests++; if (mask !== 16'h000C) begin fails++;
      $display("FAIL n4_mask: got %h expected 000c", mask); end
    tick();
    tests++; if ({ena, sof, stb} !== 3'b110 || chip !== 16'd0) begin fails++;
      $display("FAIL n4_run0: got ena/sof/stb=%b chip=%0d expected 110 chip=0", {ena, sof, stb}, chip); end
    run(60, -1, 14);
    tests++; if (r_strobes !== 30) begin fails++;
      $display("FAIL n4_strobes: got %0d expected 30", r_strobes); end
    tests++; if (r_done !== 31) begin fails++;
      $display("FAIL n4_done_cycle: got %0d expected 31", r_done); end
    tests++; if (r_sofs !== 1 || sof_at[0] !== 15) begin fails++;
      $display("FAIL n4_sof: got count=%0d first=%0d expected 1 at 15", r_sofs, sof_at[0]); end
    tests++; if (r_chip_cap !== 14) begin fails++;
      $display("FAIL n4_chip14: got %0d expected 14", r_chip_cap); end
    tests++; if (r_first_rep !== 15 || r_reps !== 2) begin fails++;
      $display("FAIL n4_period: got first=%0d reps=%0d expected 15 2", r_first_rep, r_reps); end
    tests++; if (busy !== 1'b1 || ena !== 1'b0) begin fails++;
      $display("FAIL n4_done_state: got busy=%b ena=%b expected 1 0", busy, ena); end
    tick();
    tests++; if (done !== 1'b0 || busy !== 1'b0) begin fails++;
      $display("FAIL n4_idle: got done=%b busy=%b expected 0 0", done, busy); end
    $display("[TB] test_seq_n4 strobes=%0d done_cyc=%0d", r_strobes, r_done);
  endtask

  task automatic test_deg2_div1();
    start_run(2, 1, 3);
    tick();
    run(60, -1, -1);
    tests++; if (r_strobes !== 9 || r_first_stb !== 2) begin fails++;
      $display("FAIL n2_strobes: got %0d first=%0d expected 9 first=2", r_strobes, r_first_stb); end
    tests++; if (r_done !== 19) begin fails++;
      $display("FAIL n2_done_cycle: got %0d expected 19", r_done); end
    tests++; if (r_sofs !== 2 || sof_at[0] !== 6 || sof_at[1] !== 12) begin fails++;
      $display("FAIL n2_sof: got count=%0d at %0d,%0d expected 2 at 6,12", r_sofs, sof_at[0], sof_at[1]); end
    tests++; if (r_first_rep !== 3 || r_reps !== 3) begin fails++;
      $display("FAIL n2_period: got first=%0d reps=%0d expected 3 3", r_first_rep, r_reps); end
    tick();
    $display("[TB] test_deg2_div1 strobes=%0d done_cyc=%0d", r_strobes, r_done);
  endtask

  task automatic test_long_deg12();
    start_run(12, 0, 1);
    tick();
    run(5000, -1, -1);
    tests++; if (r_strobes !== 4095) begin fails++;
      $display("FAIL n12_strobes: got %0d expected 4095", r_strobes); end
    tests++; if (r_done !== 4096) begin fails++;
      $display("FAIL n12_done_cycle: got %0d expected 4096", r_done); end
    tests++; if (r_first_rep !== 4095 || r_reps !== 1 || r_sofs !== 0) begin fails++;
      $display("FAIL n12_period: got first=%0d reps=%0d sofs=%0d expected 4095 1 0", r_first_rep, r_reps, r_sofs); end
    tick();
    $display("[TB] test_long_deg12 strobes=%0d done_cyc=%0d", r_strobes, r_done);
  endtask

  task automatic test_continuous();
    bit seen_done;
    start_run(5, 3, 0);
    tick();
    run(403, -1, -1);
    tests++; if (r_strobes !== 100 || r_first_stb !== 4) begin fails++;
      $display("FAIL n5_strobes: got %0d first=%0d expected 100 first=4", r_strobes, r_first_stb); end
    tests++; if (r_done !== -1) begin fails++;
      $display("FAIL n5_no_done: got done at %0d expected none", r_done); end
    tests++; if (r_sofs !== 3 || sof_at[0] !== 124 || sof_at[2] !== 372) begin fails++;
      $display("FAIL n5_sof: got count=%0d at %0d..%0d expected 3 at 124..372", r_sofs, sof_at[0], sof_at[2]); end
    tests++; if (r_first_rep !== 31 || r_reps !== 3) begin fails++;
      $display("FAIL n5_period: got first=%0d reps=%0d expected 31 3", r_first_rep, r_reps); end
    // divider is at div now, so a strobe is due next cycle unless stopped
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tests++; if ({ena, stb, busy} !== 3'b000) begin fails++;
      $display("FAIL n5_stop: got ena/stb/busy=%b expected 000", {ena, stb, busy}); end
    seen_done = done;
    repeat (4) begin
      tick();
      seen_done |= done;
    end
    tests++; if (seen_done !== 1'b0) begin fails++;
      $display("FAIL n5_stop_no_done: got %b expected 0", seen_done); end
    $display("[TB] test_continuous strobes=%0d", r_strobes);
  endtask

  task automatic test_ignore_start();
    start_run(6, 1, 1);
    tick();
    run(200, 9, -1);
    tests++; if (r_strobes !== 63 || r_first_stb !== 2) begin fails++;
      $display("FAIL n6_strobes: got %0d first=%0d expected 63 first=2", r_strobes, r_first_stb); end
    tests++; if (r_done !== 127) begin fails++;
      $display("FAIL n6_done_cycle: got %0d expected 127", r_done); end
    tests++; if (r_first_rep !== 63 || r_reps !== 1) begin fails++;
      $display("FAIL n6_period: got first=%0d reps=%0d expected 63 1", r_first_rep, r_reps); end
    tests++; if (mask !== 16'h0030) begin fails++;
      $display("FAIL n6_mask_kept: got %h expected 0030", mask); end
    tick();
    tests++; if (busy !== 1'b0 || mask !== 16'h0030) begin fails++;
      $display("FAIL n6_idle: got busy=%b mask=%h expected 0 0030", busy, mask); end
    $display("[TB] test_ignore_start strobes=%0d done_cyc=%0d", r_strobes, r_done);
  endtask

  task automatic test_async_reset();
    start_run(8, 2, 0);
    tick();
    run(20, -1, -1);
    tests++; if (r_strobes !== 6 || ena !== 1'b1) begin fails++;
      $display("FAIL n8_pre_reset: got strobes=%0d ena=%b expected 6 1", r_strobes, ena); end
    #3;
    rst_n = 1'b0;
    #1;
    tests++; if ({ena, stb, sof, busy, done, cerr} !== 6'b0 || mask !== 16'h0 || chip !== 16'h0) begin fails++;
      $display("FAIL async_reset: got ctl=%b mask=%h chip=%h expected 0", {ena, stb, sof, busy, done, cerr}, mask, chip); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    start_run(8, 0, 0);
    tests++; if (mask !== 16'h00B8 || busy !== 1'b1) begin fails++;
      $display("FAIL n8_rearm: got mask=%h busy=%b expected 00b8 1", mask, busy); end
    tick();
    tests++; if (sof !== 1'b1 || chip !== 16'd0 || ena !== 1'b1) begin fails++;
      $display("FAIL n8_restart: got sof=%b chip=%0d ena=%b expected 1 0 1", sof, chip, ena); end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++;
      $display("FAIL n8_stop: got busy=%b expected 0", busy); end
    $display("[TB] test_async_reset done");
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    degree = '0; div_v = '0; nseq = '0; cur_lmask = 16'h000F;
    test_reset();
    test_masks();
    test_cfg_err();
    test_seq_n4();
    test_deg2_div1();
    test_long_deg12();
    test_continuous();
    test_ignore_start();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
